note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Plays a song stored in an external song ROM.
- Drives the 10-bit note number and enable that the note decoder / sine-wave playback chain consumes.
- Each ROM entry holds a note and a duration. The block fetches entries, holds each note for its duration in tempo ticks, and signals completion or loops.
- Sits between the top-level controls (buttons/switches) and the note decoder.

Parameters:
- ADDR_W, 8, song ROM address width (max 2^ADDR_W entries).
- TICK_DIV, 250000, clk cycles per duration unit (tempo tick); must be >= 2.
- LOOP, 0, 1 = restart at address 0 on end marker; 0 = stop.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin playback from address 0
- stop  in  1  one-cycle pulse; abort playback
- rom_addr  out  ADDR_W  song ROM address
- rom_data  in  16  song ROM entry; valid exactly one clk after rom_addr changes
- note  out  10  note number to decoder; 0 = rest
- enable  out  1  decoder enable; high only while playing a non-zero note
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the song ends normally

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Entry format: rom_data[15:6] = note, rom_data[5:0] = duration in ticks (1..63). Duration 0 = end marker; its note field is ignored.
- Reset: state IDLE; rom_addr=0, note=0, enable=0, busy=0, done=0; tick and duration counters cleared.
- State machine:
  - IDLE: outputs note=0, enable=0, rom_addr=0. start (without stop) -> FETCH. All other inputs ignored.
  - FETCH: rom_addr stable for one cycle -> LATCH.
  - LATCH: sample rom_data.
    - End marker with LOOP=1 and rom_addr!=0: rom_addr<=0 -> FETCH.
    - End marker otherwise: -> IDLE, done=1 for one cycle, note<=0, enable<=0.
    - Otherwise: note<=rom_data[15:6]; enable<=(rom_data[15:6]!=0); dur_cnt<=duration; tick_cnt<=0; rom_addr<=rom_addr+1 -> PLAY.
  - PLAY: tick_cnt increments each clk. At tick_cnt==TICK_DIV-1 it wraps to 0 and dur_cnt decrements. On the wrap where dur_cnt==1 -> FETCH.
- Note timing:
  - note and enable hold their values through FETCH and LATCH and change only in LATCH, so there are no glitches to the decoder.
  - Consequently each note lasts duration*TICK_DIV + 2 clks. This 2-clk overhead is accepted.
- First note: note/enable update 2 clks after start (start seen in IDLE -> FETCH -> LATCH; registered outputs valid the cycle after LATCH).
- Address wrap: rom_addr increments modulo 2^ADDR_W. A ROM without an end marker plays forever.
- Empty song (end marker at address 0) with LOOP=1: done pulse and return to IDLE, no infinite loop.
- stop: from any non-IDLE state -> IDLE next clk; note=0, enable=0, rom_addr=0, no done pulse.
- start while busy: ignored.
- start and stop in the same cycle: stop wins; block stays/returns IDLE.
- reset mid-song: identical to the reset state on the next clk; no done pulse.
- Register all outputs. done is never high in the same cycle as busy=0 followed by a new start.

Decomposition:
- Package note_seq_pkg:
  - state enum (IDLE, FETCH, LATCH, PLAY)
  - entry field constants: NOTE_MSB=15, NOTE_LSB=6, DUR_MSB=5, DUR_LSB=0
  - NOTE_REST=10'd0, DUR_END=6'd0
- Sub-module tick_prescaler:
  - counts 0..TICK_DIV-1 and emits a one-cycle tick pulse
  - synchronous clear input, asserted in LATCH

Test Plan (TICK_DIV=4, 4-entry behavioural ROM unless noted):
- ROM {note 5 dur 2, note 9 dur 1, end}, start at cycle 0 -> note=5, enable=1 from cycle 3 for 10 clks; then note=9 for 6 clks; then done pulse, busy=0, note=0, enable=0.
- Rest entry {note 0 dur 3} -> note=0, enable=0 for 14 clks, busy stays 1.
- LOOP=1, ROM {note 7 dur 1, end} -> rom_addr sequence 0,1,0,1...; note=7 repeats; done never asserts; stop -> IDLE next clk, enable=0, no done.
- LOOP=1, ROM {end} -> done pulse 2 clks after start, then busy=0.
- Stimulus (a): start+stop in the same cycle -> stays IDLE. Stimulus (b): start pulsed during PLAY -> ignored, playback continues unchanged.
- reset asserted mid-PLAY -> next clk all outputs 0, rom_addr=0; a subsequent start replays from entry 0.

Source files
------------

// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state type and song entry layout for the note sequencer
package note_seq_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;
  localparam int NOTE_MSB = 15;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB = 5;
  localparam int DUR_LSB = 0;
  localparam logic [9:0] NOTE_REST = 10'd0;
  localparam logic [5:0] DUR_END = 6'd0;
endpackage

// File: rtl/note_sequencer_tick.sv
// tick_prescaler: divides clk into one-cycle tempo tick pulses
module tick_prescaler #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: fetches note/duration entries from a song ROM and drives the note decoder
module note_sequencer import note_seq_pkg::*; #(
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 250000,
  parameter bit LOOP     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [9:0]        note,
  output logic              enable,
  output logic              busy,
  output logic              done
);
  state_t state, state_d;
  logic [5:0] dur_cnt, dur_d;
  logic [ADDR_W-1:0] addr_d;
  logic [9:0] note_d;
  logic enable_d, done_d, tick, is_end, wrap_back, last, load;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clr(state == LATCH),
    .en(state == PLAY),
    .tick(tick)
  );
  assign is_end = rom_data[DUR_MSB:DUR_LSB] == DUR_END;
  assign wrap_back = LOOP && rom_addr != '0;
  assign last = tick && dur_cnt == 6'd1;
  assign load = state == LATCH && !is_end;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      rom_addr <= '0;
      note <= NOTE_REST;
      enable <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      dur_cnt <= DUR_END;
    end else begin
      state <= state_d;
      rom_addr <= addr_d;
      note <= note_d;
      enable <= enable_d;
      busy <= state_d != IDLE;
      done <= done_d;
      dur_cnt <= dur_d;
    end
  always_comb
    state_d = state == IDLE  ? (start && !stop ? FETCH : IDLE)
            : stop           ? IDLE
            : state == FETCH ? LATCH
            : state == LATCH ? (is_end ? (wrap_back ? FETCH : IDLE) : PLAY)
            : last           ? FETCH : PLAY;
  always_comb begin
    note_d = state_d == IDLE ? NOTE_REST : load ? rom_data[NOTE_MSB:NOTE_LSB] : note;
    enable_d = state_d == IDLE ? 1'b0 : load ? rom_data[NOTE_MSB:NOTE_LSB] != NOTE_REST : enable;
    addr_d = state_d == IDLE || (state == LATCH && is_end) ? '0 : load ? rom_addr + 1'b1 : rom_addr;
    dur_d = state_d == IDLE ? DUR_END : load ? rom_data[DUR_MSB:DUR_LSB] : state == PLAY && tick ? dur_cnt - 6'd1 : dur_cnt;
    done_d = state == LATCH && is_end && !wrap_back && !stop;
  end
endmodule
